// File: rtl/matmul_apb_master.sv
// APB master sequencer feeding the matmul accelerator's slave port.
// Takes one host request at a time, holds writes while the accelerator is busy, returns one response.
module matmul_apb_master #(
  parameter  int DATA_WIDTH = 16,
  parameter  int BUS_WIDTH  = 64,
  parameter  int ADDR_WIDTH = 16,
  parameter  int TIMEOUT    = 255,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [BUS_WIDTH-1:0]  req_wdata_i,
  input  logic [MAX_DIM-1:0]    req_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  busy_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HOLD, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  lat_write_q;
  logic [ADDR_WIDTH-1:0] lat_addr_q;
  logic [BUS_WIDTH-1:0]  lat_wdata_q;
  logic [MAX_DIM-1:0]    lat_strb_q;
  logic [CNT_W-1:0]      tmo_cnt_q;
  logic                  tmo_hit;
  logic                  rsp_valid_q;
  logic [BUS_WIDTH-1:0]  rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic                  apb_active;

  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = (req_write_i && busy_i) ? HOLD : SETUP;
      HOLD:    if (!busy_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || tmo_hit) state_d = RESP;
      RESP:    if (rsp_valid_q && rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      lat_write_q   <= 1'b0;
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
      lat_strb_q    <= '0;
      tmo_cnt_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            lat_write_q   <= req_write_i;
            lat_addr_q    <= req_addr_i;
            lat_wdata_q   <= req_wdata_i;
            lat_strb_q    <= req_strb_i;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
          end
        end
        SETUP: tmo_cnt_q <= '0;
        ACCESS: begin
          if (pready_i) begin
            rsp_rdata_q   <= lat_write_q ? '0 : prdata_i;
            rsp_err_q     <= pslverr_i;
            rsp_timeout_q <= 1'b0;
          end else if (tmo_hit) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
        // Response is presented one cycle after capture and dropped on the handshake
        RESP: rsp_valid_q <= !(rsp_valid_q && rsp_ready_i);
        default: ;
      endcase
    end
  end

  assign apb_active    = (state_q == SETUP) || (state_q == ACCESS);
  assign psel_o        = apb_active;
  assign penable_o     = (state_q == ACCESS);
  assign pwrite_o      = apb_active && lat_write_q;
  assign paddr_o       = apb_active ? lat_addr_q : '0;
  assign pwdata_o      = (apb_active && lat_write_q) ? lat_wdata_q : '0;
  assign pstrb_o       = (apb_active && lat_write_q) ? lat_strb_q : '0;
  assign req_ready_o   = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Self-checking bench for matmul_apb_master: cycle-accurate APB/host checks plus a response scoreboard.
module tb_matmul_apb_master;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [15:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [3:0]  req_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [15:0] paddr_o;
  logic [63:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i, pslverr_i;
  logic [63:0] prdata_i;
  logic        busy_i;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  matmul_apb_master #(
    .DATA_WIDTH(16), .BUS_WIDTH(64), .ADDR_WIDTH(16), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i), .busy_i(busy_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Slave/busy drive for the cycle j relative to the acceptance edge
  task automatic driveSlave(input int j, input int setup_at, input int acc, input int stall,
                            input int busy_cyc, input logic slverr, input logic [63:0] rdata);
    bit in_acc;
    in_acc    = (j >= setup_at + 1) && (j <= setup_at + acc);
    busy_i    = (j + 1 < busy_cyc);
    prdata_i  = {$urandom(), $urandom()};
    if (in_acc) begin
      pready_i  = ((j - setup_at - 1) == stall);
      pslverr_i = pready_i ? slverr : 1'b0;
      if (pready_i) prdata_i = rdata;
    end else begin
      pready_i  = 1'b1;
      pslverr_i = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [63:0] wdata,
                               input logic [3:0] strb, input int busy_cyc, input int stall,
                               input logic slverr, input logic [63:0] rdata, input int hold,
                               input bit keep_valid, input logic [15:0] nb_addr);
    int   setup_at, acc, rsp_start;
    bit   to;
    exp_t e, got;
    to        = (stall >= TMO);
    acc       = to ? TMO : stall + 1;
    setup_at  = (wr && busy_cyc > 0) ? busy_cyc : 0;
    rsp_start = setup_at + acc + 2;
    e.to      = to;
    e.err     = to | slverr;
    e.rdata   = (to || wr) ? 64'h0 : rdata;

    checkOutput("req_ready_idle", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_strb_i  = strb;
    rsp_ready_i = (hold == 0);
    driveSlave(-1, setup_at, acc, stall, busy_cyc, slverr, rdata);
    tick;
    sb_q.push_back(e);
    if (keep_valid) begin
      req_write_i = 1'b0;
      req_addr_i  = nb_addr;
    end else begin
      req_valid_i = 1'b0;
      req_write_i = ~wr;
      req_addr_i  = 16'($urandom());
      req_wdata_i = {$urandom(), $urandom()};
      req_strb_i  = 4'($urandom());
    end

    for (int j = 0; j < rsp_start; j++) begin
      bit sel_exp;
      sel_exp = (j >= setup_at) && (j <= setup_at + acc);
      checkOutput($sformatf("psel j=%0d", j), psel_o, sel_exp);
      checkOutput($sformatf("penable j=%0d", j), penable_o, sel_exp && (j > setup_at));
      checkOutput($sformatf("rsp_valid j=%0d", j), rsp_valid_o, 1'b0);
      checkOutput($sformatf("req_ready j=%0d", j), req_ready_o, 1'b0);
      if (sel_exp) begin
        checkOutput($sformatf("paddr j=%0d", j), paddr_o, addr);
        checkOutput($sformatf("pwrite j=%0d", j), pwrite_o, wr);
        checkOutput($sformatf("pwdata j=%0d", j), pwdata_o, wr ? wdata : 64'h0);
        checkOutput($sformatf("pstrb j=%0d", j), pstrb_o, wr ? strb : 4'h0);
      end
      driveSlave(j, setup_at, acc, stall, busy_cyc, slverr, rdata);
      tick;
    end

    checkOutput("rsp_valid_start", rsp_valid_o, 1'b1);
    if (sb_q.size() == 0) begin
      checkOutput("sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
    end
    for (int h = 0; h <= hold; h++) begin
      got = '{rdata: rsp_rdata_o, err: rsp_err_o, to: rsp_timeout_o};
      checkOutput($sformatf("rsp_valid h=%0d", h), rsp_valid_o, 1'b1);
      checkOutput($sformatf("rsp_rdata h=%0d", h), got.rdata, e.rdata);
      checkOutput($sformatf("rsp_err h=%0d", h), got.err, e.err);
      checkOutput($sformatf("rsp_timeout h=%0d", h), got.to, e.to);
      checkOutput($sformatf("rsp req_ready h=%0d", h), req_ready_o, 1'b0);
      checkOutput($sformatf("rsp psel h=%0d", h), psel_o, 1'b0);
      rsp_ready_i = (h == hold);
      tick;
    end
    checkOutput("rsp_valid_after_hs", rsp_valid_o, 1'b0);
    checkOutput("req_ready_after_hs", req_ready_o, 1'b1);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_strb_i  = '0;
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
    prdata_i    = '0;
    busy_i      = 1'b0;
    repeat (3) tick;
    checkOutput("rst req_ready", req_ready_o, 1'b0);
    checkOutput("rst psel", psel_o, 1'b0);
    checkOutput("rst penable", penable_o, 1'b0);
    checkOutput("rst pwrite", pwrite_o, 1'b0);
    checkOutput("rst paddr", paddr_o, 16'h0);
    checkOutput("rst pwdata", pwdata_o, 64'h0);
    checkOutput("rst pstrb", pstrb_o, 4'h0);
    checkOutput("rst rsp_valid", rsp_valid_o, 1'b0);
    checkOutput("rst rsp_err", rsp_err_o, 1'b0);
    checkOutput("rst rsp_timeout", rsp_timeout_o, 1'b0);
    checkOutput("rst rsp_rdata", rsp_rdata_o, 64'h0);
    rst_i = 1'b0;
    tick;
    checkOutput("post_rst req_ready", req_ready_o, 1'b1);

    $display("[TB] read, immediate pready");
    applyStimulus(1'b0, 16'h0008, 64'h0, 4'h0, 0, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 16'h0);
    tick;

    $display("[TB] write held by busy");
    applyStimulus(1'b1, 16'h0010, 64'hDEAD_BEEF_0000_0001, 4'b1111, 5, 0, 1'b0, 64'h0, 0, 1'b0, 16'h0);
    tick;

    $display("[TB] read timeout");
    applyStimulus(1'b0, 16'h0018, 64'h0, 4'h0, 0, 10, 1'b0, 64'h5555_AAAA_5555_AAAA, 0, 1'b0, 16'h0);
    tick;

    $display("[TB] write with slave error, response held");
    applyStimulus(1'b1, 16'h0020, 64'h1122_3344_5566_7788, 4'b0101, 0, 2, 1'b1, 64'h0, 3, 1'b0, 16'h0);
    tick;

    $display("[TB] back-to-back reads, busy ignored");
    applyStimulus(1'b0, 16'h0030, 64'h0, 4'h0, 3, 1, 1'b0, 64'hCAFE_F00D_1234_0001, 0, 1'b1, 16'h0038);
    applyStimulus(1'b0, 16'h0038, 64'h0, 4'h0, 2, 0, 1'b0, 64'hCAFE_F00D_1234_0002, 0, 1'b0, 16'h0);
    tick;

    $display("[TB] reset during access");
    checkOutput("rstmid req_ready", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 16'h0040;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
    tick;
    req_valid_i = 1'b0;
    tick;
    checkOutput("rstmid penable", penable_o, 1'b1);
    rst_i = 1'b1;
    tick;
    checkOutput("rstmid psel", psel_o, 1'b0);
    checkOutput("rstmid penable_off", penable_o, 1'b0);
    checkOutput("rstmid paddr", paddr_o, 16'h0);
    checkOutput("rstmid rsp_valid", rsp_valid_o, 1'b0);
    checkOutput("rstmid req_ready_rst", req_ready_o, 1'b0);
    rst_i    = 1'b0;
    pready_i = 1'b1;
    #1;
    checkOutput("rstmid req_ready_rel", req_ready_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick;
      checkOutput($sformatf("rstmid rsp_valid k=%0d", k), rsp_valid_o, 1'b0);
      checkOutput($sformatf("rstmid idle_ready k=%0d", k), req_ready_o, 1'b1);
    end

    checkOutput("sb_leftover", 64'(sb_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
